// File: rtl/quant_pkg.sv
// quant_pkg: shared types, limits and the saturating clip helper for the
// requantizer datapath.
//
// Widths come from the ACC_WIDTH / DATA_WIDTH macros (32 / 8 by default).
// The product, round and zero-point intermediates are sized here so every
// lane agrees on them.
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package quant_pkg;

  localparam int ACC_W   = `ACC_WIDTH;
  localparam int DATA_W  = `DATA_WIDTH;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 6;
  localparam int PROD_W  = ACC_W + SCALE_W;

  localparam int DATA_MAX = (1 << (DATA_W - 1)) - 1;
  localparam int DATA_MIN = -(1 << (DATA_W - 1));

  typedef logic signed [ACC_W-1:0]   acc_t;
  typedef logic signed [DATA_W-1:0]  data_t;
  typedef logic signed [SCALE_W-1:0] scale_t;
  typedef logic        [SHIFT_W-1:0] shift_t;
  typedef logic signed [PROD_W-1:0]  prod_t;
  // One guard bit so adding the rounding bias can never overflow.
  typedef logic signed [PROD_W:0]    rnd_t;
  // One more bit so adding the zero point can never wrap.
  typedef logic signed [PROD_W+1:0]  sum_t;

  typedef struct packed {
    data_t data;
    logic  clip;
  } clip_t;

  function automatic clip_t sat_clip(input sum_t wide);
    clip_t res;
    if (wide > sum_t'(DATA_MAX)) begin
      res.data = data_t'(DATA_MAX);
      res.clip = 1'b1;
    end else if (wide < sum_t'(DATA_MIN)) begin
      res.data = data_t'(DATA_MIN);
      res.clip = 1'b1;
    end else begin
      res.data = data_t'(wide);
      res.clip = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane: one lane of the requantizer, three register stages.
//   S1: acc * scale, snapshot of shift and zp
//   S2: round-half-up arithmetic right shift
//   S3: zero-point add and saturation
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en         global pipeline advance; all stages hold when low
//   acc        signed accumulator input
//   scale      signed multiplier (consumed in S1)
//   shift      right-shift amount (snapshotted in S1)
//   zp         signed zero point (snapshotted in S1)
//   data, sat  registered result and clip flag
module requant_lane
  import quant_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [ACC_W-1:0]   acc,
  input  logic [SCALE_W-1:0] scale,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [DATA_W-1:0]  zp,
  output logic [DATA_W-1:0]  data,
  output logic               sat
);

  prod_t  prod;
  prod_t  p1_q;
  shift_t sh1_q;
  data_t  zp1_q;

  shift_t eff_sh;
  rnd_t   bias;
  rnd_t   r2_d;
  rnd_t   r2_q;
  data_t  zp2_q;

  sum_t   wide;
  clip_t  clip;
  data_t  data_q;
  logic   sat_q;

  assign prod = prod_t'(acc_t'(acc)) * prod_t'(scale_t'(scale));

  // Shifts at or beyond the product width all round to the same result, so
  // clamping keeps the bias inside the guarded width.
  always_comb begin
    eff_sh = (sh1_q > shift_t'(PROD_W)) ? shift_t'(PROD_W) : sh1_q;
    bias   = (eff_sh == '0) ? '0 : (rnd_t'(1) << (eff_sh - shift_t'(1)));
    r2_d   = (rnd_t'(p1_q) + bias) >>> eff_sh;
  end

  always_comb begin
    wide = sum_t'(r2_q) + sum_t'(zp2_q);
    clip = sat_clip(wide);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q   <= '0;
      sh1_q  <= '0;
      zp1_q  <= '0;
      r2_q   <= '0;
      zp2_q  <= '0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else if (en) begin
      p1_q   <= prod;
      sh1_q  <= shift;
      zp1_q  <= zp;
      r2_q   <= r2_d;
      zp2_q  <= zp1_q;
      data_q <= clip.data;
      sat_q  <= clip.clip;
    end
  end

  assign data = data_q;
  assign sat  = sat_q;

endmodule

// File: rtl/requantizer_pipe.sv
// requantizer_pipe: multi-lane pipelined accumulator-to-activation
// requantizer (scale, rounding shift, zero point, saturation), 3-cycle
// latency, 1 beat/cycle, valid/ready on both sides.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_we, cfg_scale/shift/zp    runtime config load (reset: 1 / 0 / 0)
//   in_valid, in_ready, in_data   input beats, lane 0 in LSBs
//   out_valid, out_ready          output handshake
//   out_data, out_sat             output lanes and per-lane clip flags
//   sat_count                     only with QUANT_SAT_CNT_EN: saturating
//                                 count of clipped lanes handed off
module requantizer_pipe
  import quant_pkg::*;
#(
  parameter int unsigned LANES       = 4,
  parameter int unsigned ACC_WIDTH   = ACC_W,
  parameter int unsigned DATA_WIDTH  = DATA_W,
  parameter int unsigned SCALE_WIDTH = SCALE_W,
  parameter int unsigned SHIFT_WIDTH = SHIFT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [SCALE_WIDTH-1:0]      cfg_scale,
  input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
  input  logic [DATA_WIDTH-1:0]       cfg_zp,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*ACC_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [LANES-1:0]            out_sat
`ifdef QUANT_SAT_CNT_EN
  ,
  output logic [31:0]                 sat_count
`endif
);

  logic [SCALE_WIDTH-1:0] scale_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0]  zp_q;
  logic                   s1_valid, s2_valid, s3_valid;
  logic                   adv;

  // Single enable for the whole pipe: bubbles move along with beats.
  assign adv       = !s3_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = s3_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      scale_q <= SCALE_WIDTH'(1);
      shift_q <= '0;
      zp_q    <= '0;
    end else if (cfg_we) begin
      scale_q <= cfg_scale;
      shift_q <= cfg_shift;
      zp_q    <= cfg_zp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (adv),
      .acc   (in_data[i*ACC_WIDTH +: ACC_WIDTH]),
      .scale (scale_q),
      .shift (shift_q),
      .zp    (zp_q),
      .data  (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .sat   (out_sat[i])
    );
  end

`ifdef QUANT_SAT_CNT_EN
  localparam int unsigned PopW = $clog2(LANES + 1);

  logic [PopW-1:0] pop;
  logic [32:0]     cnt_sum;
  logic [31:0]     sat_count_q;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pop = pop + PopW'(out_sat[i]);
    end
    cnt_sum = {1'b0, sat_count_q} + 33'(pop);
  end

  // A config load starts a fresh measurement window.
  always_ff @(posedge clk) begin
    if (rst || cfg_we) begin
      sat_count_q <= '0;
    end else if (out_valid && out_ready) begin
      sat_count_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_requantizer_pipe.sv
// Self-checking bench for requantizer_pipe: directed scenarios plus a
// randomized stream checked against an arithmetic reference model.
module tb_requantizer_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_we = 1'b0;
  logic [15:0]  cfg_scale = '0;
  logic [5:0]   cfg_shift = '0;
  logic [7:0]   cfg_zp = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic [3:0]   out_sat;
`ifdef QUANT_SAT_CNT_EN
  logic [31:0]  sat_count;
`endif

  int n_checks = 0;
  int n_pass = 0;

  // Model view of the config registers and the expected/observed beats
  // as {sat, data}.
  logic signed [15:0] m_scale = 16'sd1;
  logic        [5:0]  m_shift = '0;
  logic signed [7:0]  m_zp = '0;
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];

  logic        t_acc, t_vld;
  logic [31:0] t_dat;
  logic [3:0]  t_sat;

  always #5 clk = ~clk;

  requantizer_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_scale (cfg_scale),
    .cfg_shift (cfg_shift),
    .cfg_zp    (cfg_zp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
`ifdef QUANT_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  // Real-valued requantization: round(x*scale / 2^shift) half up, + zp, clamp.
  function automatic logic [35:0] model_beat(input logic [127:0] din,
                                             input logic signed [15:0] sc,
                                             input logic [5:0] sh,
                                             input logic signed [7:0] zp);
    logic [31:0] d;
    logic [3:0]  s;
    longint p, r, v, bias;
    d = '0;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      p    = longint'($signed(din[i*32 +: 32])) * longint'(sc);
      bias = (sh == 0) ? 0 : (longint'(1) << (sh - 1));
      r    = (p + bias) >>> sh;
      v    = r + longint'(zp);
      if (v > 127) begin
        d[i*8 +: 8] = 8'h7f;
        s[i] = 1'b1;
      end else if (v < -128) begin
        d[i*8 +: 8] = 8'h80;
        s[i] = 1'b1;
      end else begin
        d[i*8 +: 8] = v[7:0];
      end
    end
    return {s, d};
  endfunction

  // One cycle, entered and left at a falling edge; records what the next
  // rising edge will do (acceptance, handshake, config load, reset).
  task automatic tick(input logic iv, input logic [127:0] din, input logic ordy);
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
    #1;
    t_acc = iv && in_ready;
    t_vld = out_valid;
    t_dat = out_data;
    t_sat = out_sat;
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      m_scale = 16'sd1;
      m_shift = '0;
      m_zp    = '0;
    end else begin
      if (t_acc) exp_q.push_back(model_beat(din, m_scale, m_shift, m_zp));
      if (t_vld && ordy) got_q.push_back({t_sat, t_dat});
      if (cfg_we) begin
        m_scale = cfg_scale;
        m_shift = cfg_shift;
        m_zp    = cfg_zp;
      end
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic flush();
    repeat (8) tick(1'b0, '0, 1'b1);
  endtask

  task automatic load_cfg(input logic [15:0] sc, input logic [5:0] sh, input logic [7:0] zp);
    cfg_scale = sc;
    cfg_shift = sh;
    cfg_zp    = zp;
    cfg_we    = 1'b1;
    tick(1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", out_data);
    else n_pass++;
    n_checks++;
    if (out_sat !== 4'h0) $display("FAIL reset_out_sat: got %b want 0", out_sat);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_legacy();
    int lat;
    lat = 0;
    tick(1'b1, pack4(100, 300, -300, -128), 1'b1);
    n_checks++;
    if (t_acc !== 1'b1) $display("FAIL legacy_accept: got %b want 1", t_acc);
    else n_pass++;
    for (int n = 1; n <= 10; n++) begin
      tick(1'b0, '0, 1'b1);
      if (t_vld) begin
        lat = n;
        break;
      end
    end
    n_checks++;
    if (lat != 3) $display("FAIL legacy_latency: got %0d want 3", lat);
    else n_pass++;
    n_checks++;
    if (t_dat !== 32'h80807f64) $display("FAIL legacy_data: got %h want 80807f64", t_dat);
    else n_pass++;
    n_checks++;
    if (t_sat !== 4'b0110) $display("FAIL legacy_sat: got %b want 0110", t_sat);
    else n_pass++;
    flush();
    n_checks++;
    if (got_q.size() != 1) $display("FAIL legacy_count: got %0d want 1", got_q.size());
    else n_pass++;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_scale_round();
    logic [127:0] din;
    din = pack4(10, -10, 2, -2);
    load_cfg(16'd3, 6'd2, 8'd0);
    tick(1'b1, din, 1'b1);
    cfg_zp = 8'd5;
    cfg_we = 1'b1;
    tick(1'b0, '0, 1'b1);
    tick(1'b1, din, 1'b1);
    flush();
    n_checks++;
    if (got_q.size() != 2) $display("FAIL round_count: got %0d want 2", got_q.size());
    else n_pass++;
    if (got_q.size() >= 2) begin
      n_checks++;
      if (got_q[0] !== {4'h0, 32'hff02f908})
        $display("FAIL round_beat0: got %h want 0ff02f908", got_q[0]);
      else n_pass++;
      n_checks++;
      if (got_q[1] !== {4'h0, 32'h0407fe0d})
        $display("FAIL round_zp_beat1: got %h want 00407fe0d", got_q[1]);
      else n_pass++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    int sent;
    logic ordy;
    logic [31:0] hold_d;
    logic [3:0]  hold_s;
    sent = 0;
    hold_d = '0;
    hold_s = '0;
    load_cfg(16'd1, 6'd0, 8'd0);
    for (int c = 0; c < 60 && sent < 20; c++) begin
      ordy = !(c >= 8 && c < 13);
      tick(1'b1, pack4(sent*4, sent*4+1, sent*4+2, sent*4+3), ordy);
      if (!ordy) begin
        n_checks++;
        if (t_acc !== 1'b0) $display("FAIL bp_in_ready_c%0d: got accept %b want 0", c, t_acc);
        else n_pass++;
        if (c > 8) begin
          n_checks++;
          if ({t_sat, t_dat} !== {hold_s, hold_d})
            $display("FAIL bp_hold_c%0d: got %h want %h", c, {t_sat, t_dat}, {hold_s, hold_d});
          else n_pass++;
        end
        hold_d = t_dat;
        hold_s = t_sat;
      end
      if (t_acc) sent++;
    end
    flush();
    n_checks++;
    if (got_q.size() != 20) $display("FAIL bp_count: got %0d want 20", got_q.size());
    else n_pass++;
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_checks++;
      if (got_q[j] !== exp_q[j] || got_q[j][7:0] !== 8'(j*4))
        $display("FAIL bp_beat%0d: got %h want %h", j, got_q[j], exp_q[j]);
      else n_pass++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_cfg_midstream();
    int v[8];
    load_cfg(16'd1, 6'd0, 8'd0);
    for (int j = 0; j < 8; j++) begin
      v[j] = int'($urandom_range(100, 0)) - 50;
      if (j == 3) begin
        cfg_scale = 16'd2;
        cfg_we    = 1'b1;
      end
      tick(1'b1, pack4(v[j], v[j] + 1, -v[j], 7), 1'b1);
    end
    flush();
    n_checks++;
    if (got_q.size() != 8) $display("FAIL cfgmid_count: got %0d want 8", got_q.size());
    else n_pass++;
    for (int j = 0; j < 8 && j < got_q.size(); j++) begin
      n_checks++;
      if (got_q[j][7:0] !== 8'((j <= 3) ? v[j] : 2 * v[j]) || got_q[j] !== exp_q[j])
        $display("FAIL cfgmid_beat%0d: got %h want lane0 %0d", j, got_q[j],
                 (j <= 3) ? v[j] : 2 * v[j]);
      else n_pass++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_midstream();
    load_cfg(16'd3, 6'd1, 8'd2);
    repeat (3) tick(1'b1, pack4(5, 6, 7, 8), 1'b0);
    rst = 1'b1;
    tick(1'b0, '0, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (t_vld !== 1'b1) $display("FAIL rstmid_loaded: got %b want 1", t_vld);
    else n_pass++;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid);
    else n_pass++;
    @(negedge clk);
    for (int n = 0; n < 6; n++) begin
      tick(1'b0, '0, 1'b1);
      n_checks++;
      if (t_vld !== 1'b0) $display("FAIL rstmid_stale%0d: got %b want 0", n, t_vld);
      else n_pass++;
    end
    tick(1'b1, pack4(300, -5, 0, 1), 1'b1);
    flush();
    n_checks++;
    if (got_q.size() != 1) $display("FAIL rstmid_count: got %0d want 1", got_q.size());
    else n_pass++;
    if (got_q.size() >= 1) begin
      n_checks++;
      if (got_q[0] !== {4'b0001, 32'h0100fb7f})
        $display("FAIL rstmid_cfg: got %h want 10100fb7f", got_q[0]);
      else n_pass++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_random();
    logic [127:0] din;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(9, 0) == 0) begin
        cfg_scale = 16'($urandom);
        cfg_shift = ($urandom_range(3, 0) == 0) ? 6'($urandom_range(63, 0))
                                                : 6'($urandom_range(24, 4));
        cfg_zp    = 8'($urandom);
        cfg_we    = 1'b1;
      end
      if ($urandom_range(1, 0) == 0) begin
        din = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        din = pack4(int'($urandom_range(2000, 0)) - 1000, int'($urandom_range(2000, 0)) - 1000,
                    int'($urandom_range(2000, 0)) - 1000, int'($urandom_range(2000, 0)) - 1000);
      end
      tick($urandom_range(3, 0) != 0, din, $urandom_range(3, 0) != 0);
    end
    flush();
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      n_checks++;
      if (got_q[j] !== exp_q[j]) $display("FAIL rand_beat%0d: got %h want %h", j, got_q[j], exp_q[j]);
      else n_pass++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

`ifdef QUANT_SAT_CNT_EN
  task automatic test_sat_count();
    load_cfg(16'd1, 6'd0, 8'd0);
    repeat (10) tick(1'b1, pack4(1000, -1000, 5, 6), 1'b1);
    flush();
    n_checks++;
    if (sat_count !== 32'd20) $display("FAIL satcnt_20: got %0d want 20", sat_count);
    else n_pass++;
    cfg_we = 1'b1;
    tick(1'b0, '0, 1'b1);
    n_checks++;
    if (sat_count !== 32'd0) $display("FAIL satcnt_clear: got %0d want 0", sat_count);
    else n_pass++;
    force dut.sat_count_q = 32'hffff_fffe;
    #1;
    release dut.sat_count_q;
    tick(1'b1, pack4(1000, -1000, 5, 6), 1'b1);
    flush();
    n_checks++;
    if (sat_count !== 32'hffff_ffff) $display("FAIL satcnt_top: got %h want ffffffff", sat_count);
    else n_pass++;
    tick(1'b1, pack4(1000, -1000, 5, 6), 1'b1);
    flush();
    n_checks++;
    if (sat_count !== 32'hffff_ffff) $display("FAIL satcnt_hold: got %h want ffffffff", sat_count);
    else n_pass++;
    exp_q.delete();
    got_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_legacy();
    test_scale_round();
    test_backpressure();
    test_cfg_midstream();
    test_reset_midstream();
    test_random();
`ifdef QUANT_SAT_CNT_EN
    test_sat_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
